// File: rtl/interrupt_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter.
// Contents:
//   state_t          arbiter FSM states (IDLE, GRANT, ACK)
//   NMI_VEC_DEF      default NMI vector LSBs (0xFFFC)
//   IRQ_VEC_TOP_DEF  default vector LSBs for IRQ[0]; IRQ[k] = top - k
//   VEC_RESET        value of IntAddrLSBs after reset
//   IDXW             width of a source index (up to 16 sources)
package interrupt_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic [5:0] NMI_VEC_DEF     = 6'h3E;
    localparam logic [5:0] IRQ_VEC_TOP_DEF = 6'h3D;
    localparam logic [5:0] VEC_RESET       = 6'h3F;
    localparam int         IDXW            = 4;

endpackage

// File: rtl/interrupt_arbiter_prio.sv
// irq_priority_encoder: purely combinational winner selection.
// NMI beats everything; otherwise the lowest-numbered eligible source wins.
// Ports:
//   nmi      in   NMI pending
//   eligible in   NSRC  pending & enable per maskable source
//   valid    out  any request present
//   is_nmi   out  the winner is the NMI
//   index    out  IDXW  winning maskable source (0 when NMI or none)
//   vec      out  6     vector LSBs for the winner
module irq_priority_encoder
    import interrupt_arbiter_pkg::*;
#(
    parameter int         NSRC        = 8,
    parameter logic [5:0] NMI_VEC     = NMI_VEC_DEF,
    parameter logic [5:0] IRQ_VEC_TOP = IRQ_VEC_TOP_DEF
) (
    input  logic            nmi,
    input  logic [NSRC-1:0] eligible,
    output logic            valid,
    output logic            is_nmi,
    output logic [IDXW-1:0] index,
    output logic [5:0]      vec
);

    logic [IDXW-1:0] low_idx;

    // Scan downward so the last hit, the lowest index, wins.
    always_comb begin
        low_idx = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (eligible[k]) low_idx = IDXW'(k);
        end
    end

    always_comb begin
        valid  = nmi | (|eligible);
        is_nmi = nmi;
        index  = nmi ? '0 : low_idx;
        vec    = nmi ? NMI_VEC : (IRQ_VEC_TOP - 6'(low_idx));
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: edge-triggered interrupt collection and CPU handshake.
// Rising edges on NMIsrc / IRQ[k] set pending flags (independent of IE).
// The highest-priority eligible request is granted by raising NMI or INT with
// a matching vector; the winner is frozen until the CPU asserts INTACK, which
// clears the winner's flag and emits a one-cycle ack pulse to that source.
// Ports:
//   MCLK, reset   clock, synchronous active-high reset
//   NMIsrc        non-maskable source (rising edge)
//   IRQ[NSRC]     maskable sources (rising edge)
//   IE[NSRC]      per-source enable (gates eligibility only)
//   INTACK        CPU acknowledge, level
//   NMI, INT      registered requests to the CPU (never both high)
//   IntAddrLSBs   registered vector LSBs
//   IrqAck, NmiAck one-cycle ack pulses
//   Pending       maskable pending flags
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int         NSRC        = 8,
    parameter logic [5:0] NMI_VEC     = NMI_VEC_DEF,
    parameter logic [5:0] IRQ_VEC_TOP = IRQ_VEC_TOP_DEF
) (
    input  logic            MCLK,
    input  logic            reset,
    input  logic            NMIsrc,
    input  logic [NSRC-1:0] IRQ,
    input  logic [NSRC-1:0] IE,
    input  logic            INTACK,
    output logic            NMI,
    output logic            INT,
    output logic [5:0]      IntAddrLSBs,
    output logic [NSRC-1:0] IrqAck,
    output logic            NmiAck,
    output logic [NSRC-1:0] Pending
);

    state_t          state;
    logic            nmi_q;
    logic [NSRC-1:0] irq_q;
    logic            nmi_pend;
    logic            win_nmi;
    logic [NSRC-1:0] win_oh;

    logic            nmi_rise;
    logic [NSRC-1:0] irq_rise;
    logic            enc_valid;
    logic            enc_nmi;
    logic [IDXW-1:0] enc_idx;
    logic [5:0]      enc_vec;
    logic [NSRC-1:0] enc_oh;
    logic            withdraw;
    logic            take_ack;
    logic [NSRC-1:0] irq_clr;
    logic            nmi_clr;

    assign nmi_rise = NMIsrc & ~nmi_q;
    assign irq_rise = IRQ & ~irq_q;

    irq_priority_encoder #(
        .NSRC       (NSRC),
        .NMI_VEC    (NMI_VEC),
        .IRQ_VEC_TOP(IRQ_VEC_TOP)
    ) u_prio (
        .nmi     (nmi_pend),
        .eligible(Pending & IE),
        .valid   (enc_valid),
        .is_nmi  (enc_nmi),
        .index   (enc_idx),
        .vec     (enc_vec)
    );

    // One-hot of the encoder's choice; zero when NMI wins.
    always_comb begin
        enc_oh = '0;
        for (int k = 0; k < NSRC; k++) begin
            enc_oh[k] = !enc_nmi && (enc_idx == IDXW'(k));
        end
    end

    // A maskable winner whose enable drops before the ack is withdrawn;
    // withdrawal takes precedence over an ack arriving on the same edge.
    always_comb begin
        withdraw = (state == ST_GRANT) && !win_nmi && ((win_oh & IE) == '0);
        take_ack = (state == ST_GRANT) && INTACK && !withdraw;
        irq_clr  = take_ack ? win_oh : '0;
        nmi_clr  = take_ack && win_nmi;
    end

    // Edge-detect and pending flags. A new edge beats a clear on the same edge.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            nmi_q    <= NMIsrc;
            irq_q    <= IRQ;
            nmi_pend <= 1'b0;
            Pending  <= '0;
        end else begin
            nmi_q    <= NMIsrc;
            irq_q    <= IRQ;
            nmi_pend <= (nmi_pend & ~nmi_clr) | nmi_rise;
            Pending  <= (Pending & ~irq_clr) | irq_rise;
        end
    end

    // Grant / acknowledge FSM with registered outputs.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            state       <= ST_IDLE;
            win_nmi     <= 1'b0;
            win_oh      <= '0;
            NMI         <= 1'b0;
            INT         <= 1'b0;
            IntAddrLSBs <= VEC_RESET;
            IrqAck      <= '0;
            NmiAck      <= 1'b0;
        end else begin
            IrqAck <= '0;
            NmiAck <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enc_valid) begin
                        state       <= ST_GRANT;
                        win_nmi     <= enc_nmi;
                        win_oh      <= enc_oh;
                        NMI         <= enc_nmi;
                        INT         <= !enc_nmi;
                        IntAddrLSBs <= enc_vec;
                    end
                end
                ST_GRANT: begin
                    if (withdraw) begin
                        state <= ST_IDLE;
                        INT   <= 1'b0;
                    end else if (take_ack) begin
                        state  <= ST_ACK;
                        NMI    <= 1'b0;
                        INT    <= 1'b0;
                        IrqAck <= win_oh;
                        NmiAck <= win_nmi;
                    end
                end
                ST_ACK: begin
                    if (!INTACK) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    NMI   <= 1'b0;
                    INT   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
module tb_interrupt_arbiter;

    localparam int NSRC = 8;

    logic            MCLK = 1'b0;
    logic            reset;
    logic            NMIsrc;
    logic [NSRC-1:0] IRQ;
    logic [NSRC-1:0] IE;
    logic            INTACK;
    logic            NMI;
    logic            INT;
    logic [5:0]      IntAddrLSBs;
    logic [NSRC-1:0] IrqAck;
    logic            NmiAck;
    logic [NSRC-1:0] Pending;

    int tests = 0;
    int fails = 0;

    interrupt_arbiter #(.NSRC(NSRC)) dut (
        .MCLK       (MCLK),
        .reset      (reset),
        .NMIsrc     (NMIsrc),
        .IRQ        (IRQ),
        .IE         (IE),
        .INTACK     (INTACK),
        .NMI        (NMI),
        .INT        (INT),
        .IntAddrLSBs(IntAddrLSBs),
        .IrqAck     (IrqAck),
        .NmiAck     (NmiAck),
        .Pending    (Pending)
    );

    always #5 MCLK = ~MCLK;

    // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; NMIsrc = 1'b0; IRQ = '0; IE = '0; INTACK = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    // At-most-one of NMI/INT, checked every cycle.
    always @(negedge MCLK) begin
        if (reset === 1'b0) begin
            tests++;
            if (NMI === 1'b1 && INT === 1'b1) begin
                fails++;
                $display("FAIL nmi_int_exclusive: NMI=%b INT=%b, want not both", NMI, INT);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; NMIsrc = 1'b1; IRQ = 8'h81; IE = 8'hFF; INTACK = 1'b0;
        tick(2);
        tests++;
        if ({NMI, INT, IntAddrLSBs, IrqAck, NmiAck, Pending} !== {1'b0, 1'b0, 6'h3F, 8'h00, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL reset_values: NMI=%b INT=%b LSBs=%h IrqAck=%h NmiAck=%b Pending=%h", NMI, INT, IntAddrLSBs, IrqAck, NmiAck, Pending);
        end
        // Sources already high through reset must not trigger.
        reset = 1'b0;
        tick(3);
        tests++;
        if ({NMI, INT, Pending} !== 10'b0) begin
            fails++;
            $display("FAIL reset_no_trigger: NMI=%b INT=%b Pending=%h, want 0 0 00", NMI, INT, Pending);
        end
        NMIsrc = 1'b0; IRQ = '0;
        tick(1);
    endtask

    task automatic test_single_irq();
        do_reset();
        IE = 8'h08; IRQ = 8'h08;
        tick(1);
        tests++;
        if (Pending !== 8'h08 || INT !== 1'b0) begin
            fails++;
            $display("FAIL single_pending_+1: Pending=%h INT=%b, want 08 0", Pending, INT);
        end
        tick(1);
        tests++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'h3A) begin
            fails++;
            $display("FAIL single_grant_+2: INT=%b LSBs=%h, want 1 3a", INT, IntAddrLSBs);
        end
        INTACK = 1'b1;
        tick(1);
        tests++;
        if (IrqAck !== 8'h08 || INT !== 1'b0 || Pending !== 8'h00) begin
            fails++;
            $display("FAIL single_ack: IrqAck=%h INT=%b Pending=%h, want 08 0 00", IrqAck, INT, Pending);
        end
        tick(1);
        tests++;
        if (IrqAck !== 8'h00) begin
            fails++;
            $display("FAIL single_ack_pulse: IrqAck=%h, want 00", IrqAck);
        end
        // New edge while INTACK still high: no regrant until it falls.
        IRQ = 8'h00;
        tick(1);
        IRQ = 8'h08;
        tick(1);
        tests++;
        if (INT !== 1'b0 || Pending !== 8'h08) begin
            fails++;
            $display("FAIL single_no_regrant_in_ack: INT=%b Pending=%h, want 0 08", INT, Pending);
        end
        tick(1);
        tests++;
        if (INT !== 1'b0) begin
            fails++;
            $display("FAIL single_no_regrant_in_ack2: INT=%b, want 0", INT);
        end
        INTACK = 1'b0;
        tick(1);
        tick(1);
        tests++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'h3A) begin
            fails++;
            $display("FAIL single_regrant_after_ack: INT=%b LSBs=%h, want 1 3a", INT, IntAddrLSBs);
        end
    endtask

    task automatic test_priority();
        do_reset();
        IE = 8'hFF; IRQ = 8'h22;
        tick(2);
        tests++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'h3C) begin
            fails++;
            $display("FAIL prio_first: INT=%b LSBs=%h, want 1 3c", INT, IntAddrLSBs);
        end
        INTACK = 1'b1;
        tick(1);
        tests++;
        if (IrqAck !== 8'h02 || Pending !== 8'h20) begin
            fails++;
            $display("FAIL prio_first_ack: IrqAck=%h Pending=%h, want 02 20", IrqAck, Pending);
        end
        INTACK = 1'b0;
        tick(1);
        // IntAddrLSBs holds outside GRANT.
        tests++;
        if (INT !== 1'b0 || IntAddrLSBs !== 6'h3C) begin
            fails++;
            $display("FAIL prio_hold_lsbs: INT=%b LSBs=%h, want 0 3c", INT, IntAddrLSBs);
        end
        tick(1);
        tests++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'h38) begin
            fails++;
            $display("FAIL prio_second: INT=%b LSBs=%h, want 1 38", INT, IntAddrLSBs);
        end
        INTACK = 1'b1;
        tick(1);
        tests++;
        if (IrqAck !== 8'h20 || Pending !== 8'h00) begin
            fails++;
            $display("FAIL prio_second_ack: IrqAck=%h Pending=%h, want 20 00", IrqAck, Pending);
        end
        INTACK = 1'b0;
        tick(1);
    endtask

    task automatic test_nmi_preempt();
        do_reset();
        IE = 8'hFF; IRQ = 8'h10;
        tick(2);
        tests++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'h39) begin
            fails++;
            $display("FAIL nmi_irq4_grant: INT=%b LSBs=%h, want 1 39", INT, IntAddrLSBs);
        end
        NMIsrc = 1'b1;
        tick(2);
        tests++;
        if (INT !== 1'b1 || NMI !== 1'b0 || IntAddrLSBs !== 6'h39) begin
            fails++;
            $display("FAIL nmi_frozen: INT=%b NMI=%b LSBs=%h, want 1 0 39", INT, NMI, IntAddrLSBs);
        end
        INTACK = 1'b1;
        tick(1);
        tests++;
        if (IrqAck !== 8'h10 || NmiAck !== 1'b0) begin
            fails++;
            $display("FAIL nmi_irq4_ack: IrqAck=%h NmiAck=%b, want 10 0", IrqAck, NmiAck);
        end
        INTACK = 1'b0;
        tick(2);
        tests++;
        if (NMI !== 1'b1 || INT !== 1'b0 || IntAddrLSBs !== 6'h3E) begin
            fails++;
            $display("FAIL nmi_grant: NMI=%b INT=%b LSBs=%h, want 1 0 3e", NMI, INT, IntAddrLSBs);
        end
        // NMI winner is not withdrawn when enables drop.
        IE = 8'h00;
        tick(2);
        tests++;
        if (NMI !== 1'b1) begin
            fails++;
            $display("FAIL nmi_no_withdraw: NMI=%b, want 1", NMI);
        end
        INTACK = 1'b1;
        tick(1);
        tests++;
        if (NmiAck !== 1'b1 || NMI !== 1'b0 || IrqAck !== 8'h00) begin
            fails++;
            $display("FAIL nmi_ack: NmiAck=%b NMI=%b IrqAck=%h, want 1 0 00", NmiAck, NMI, IrqAck);
        end
        INTACK = 1'b0; NMIsrc = 1'b0;
        tick(3);
        tests++;
        if (NMI !== 1'b0) begin
            fails++;
            $display("FAIL nmi_cleared: NMI=%b, want 0", NMI);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        IE = 8'hFF; IRQ = 8'h04;
        tick(2);
        tests++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'h3B) begin
            fails++;
            $display("FAIL wd_grant: INT=%b LSBs=%h, want 1 3b", INT, IntAddrLSBs);
        end
        IE = 8'hFB;
        tick(1);
        tests++;
        if (INT !== 1'b0 || Pending !== 8'h04) begin
            fails++;
            $display("FAIL wd_withdrawn: INT=%b Pending=%h, want 0 04", INT, Pending);
        end
        tick(1);
        tests++;
        if (INT !== 1'b0) begin
            fails++;
            $display("FAIL wd_stays_off: INT=%b, want 0", INT);
        end
        IE = 8'hFF;
        tick(1);
        tests++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'h3B) begin
            fails++;
            $display("FAIL wd_regrant: INT=%b LSBs=%h, want 1 3b", INT, IntAddrLSBs);
        end
        INTACK = 1'b1;
        tick(1);
        INTACK = 1'b0;
        tick(1);
    endtask

    task automatic test_set_beats_clear();
        do_reset();
        IE = 8'h01; IRQ = 8'h01;
        tick(2);
        IRQ = 8'h00;
        tick(1);
        tests++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'h3D) begin
            fails++;
            $display("FAIL sbc_grant: INT=%b LSBs=%h, want 1 3d", INT, IntAddrLSBs);
        end
        INTACK = 1'b1; IRQ = 8'h01;
        tick(1);
        tests++;
        if (IrqAck !== 8'h01 || Pending !== 8'h01) begin
            fails++;
            $display("FAIL sbc_pending_kept: IrqAck=%h Pending=%h, want 01 01", IrqAck, Pending);
        end
        tick(1);
        tests++;
        if (INT !== 1'b0) begin
            fails++;
            $display("FAIL sbc_hold_in_ack: INT=%b, want 0", INT);
        end
        INTACK = 1'b0;
        tick(2);
        tests++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'h3D) begin
            fails++;
            $display("FAIL sbc_regrant: INT=%b LSBs=%h, want 1 3d", INT, IntAddrLSBs);
        end
    endtask

    task automatic test_masked_and_idle_ack();
        do_reset();
        IE = 8'h00; IRQ = 8'h02;
        tick(3);
        tests++;
        if (Pending !== 8'h02 || INT !== 1'b0) begin
            fails++;
            $display("FAIL masked_pending: Pending=%h INT=%b, want 02 0", Pending, INT);
        end
        INTACK = 1'b1;
        tick(2);
        tests++;
        if (Pending !== 8'h02 || IrqAck !== 8'h00 || INT !== 1'b0) begin
            fails++;
            $display("FAIL idle_intack_ignored: Pending=%h IrqAck=%h INT=%b, want 02 00 0", Pending, IrqAck, INT);
        end
        INTACK = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        IE = 8'hFF; IRQ = 8'h40;
        tick(2);
        tests++;
        if (INT !== 1'b1 || IntAddrLSBs !== 6'h37) begin
            fails++;
            $display("FAIL rmg_grant: INT=%b LSBs=%h, want 1 37", INT, IntAddrLSBs);
        end
        reset = 1'b1;
        tick(1);
        tests++;
        if ({NMI, INT, IntAddrLSBs, IrqAck, NmiAck, Pending} !== {1'b0, 1'b0, 6'h3F, 8'h00, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL rmg_reset_values: NMI=%b INT=%b LSBs=%h IrqAck=%h NmiAck=%b Pending=%h", NMI, INT, IntAddrLSBs, IrqAck, NmiAck, Pending);
        end
        reset = 1'b0;
        tick(4);
        tests++;
        if (INT !== 1'b0 || Pending !== 8'h00 || IntAddrLSBs !== 6'h3F) begin
            fails++;
            $display("FAIL rmg_no_grant: INT=%b Pending=%h LSBs=%h, want 0 00 3f", INT, Pending, IntAddrLSBs);
        end
    endtask

    initial begin
        reset = 1'b1; NMIsrc = 1'b0; IRQ = '0; IE = '0; INTACK = 1'b0;
        #2;
        test_reset();
        test_single_irq();
        test_priority();
        test_nmi_preempt();
        test_withdraw();
        test_set_beats_clear();
        test_masked_and_idle_ack();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
